// File: rtl/ncmem_noc2_pkt_buf.sv
// ncmem_noc2_pkt_buf
//   Store-and-forward NoC2 packet buffer sitting in front of the ncmem
//   NoC-to-AXI4 bridge, on the chipset clock. A packet is offered to the
//   bridge only once its tail flit has been written. The only exception is a
//   packet longer than the FIFO ("oversize"), which is forwarded cut-through
//   so that it can never deadlock the buffer.
//
//   Handshake (both sides): a flit transfers on a rising edge where val && rdy.
//   val does not depend on rdy. Nothing transfers in a cycle where reset is
//   sampled.
//
//   Optional feature macro: NCMEM_PKT_BUF_STATS_EN
//     defined   -> pkt_fwd_cnt counts every tail pop (32-bit, wraps)
//     undefined -> pkt_fwd_cnt is tied to 0 and no counter flops exist
//
// Ports
//   chipset_clk, chipset_rst       clock, synchronous active-high reset
//   noc2_in_val/dat/rdy            upstream flit stream from the crossbar
//   noc2_out_val/dat/rdy           flit stream to the bridge (FWFT head)
//   pkt_cnt                        complete (non-oversize) packets held
//   pkt_fwd_cnt                    packets forwarded (stats build only)
//
// Internal FSM state (in_state, out_state) uses the plain fsm_t encoding so
// checkers can bind to it directly.

module ncmem_noc2_pkt_buf #(
  parameter int NOC_DATA_WIDTH = 64,
  parameter int FLIT_DEPTH     = 16
) (
  input  logic                          chipset_clk,
  input  logic                          chipset_rst,
  input  logic                          noc2_in_val,
  input  logic [NOC_DATA_WIDTH-1:0]     noc2_in_dat,
  output logic                          noc2_in_rdy,
  output logic                          noc2_out_val,
  output logic [NOC_DATA_WIDTH-1:0]     noc2_out_dat,
  input  logic                          noc2_out_rdy,
  output logic [$clog2(FLIT_DEPTH):0]   pkt_cnt,
  output logic [31:0]                   pkt_fwd_cnt
);

  localparam int AW = $clog2(FLIT_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {HDR = 1'b0, BODY = 1'b1} fsm_t;

  logic [NOC_DATA_WIDTH-1:0] mem [FLIT_DEPTH];
  logic [AW-1:0]             wr_ptr, rd_ptr;
  logic [CW-1:0]             flit_cnt, pkt_cnt_q;
  logic                      rst_done;
  fsm_t                      in_state, in_state_nxt, out_state, out_state_nxt;
  logic [7:0]                in_rem, out_rem;
  logic                      ovs, ovs_head, out_ovs;
  logic                      push, pop;
  logic [7:0]                in_len, head_len;
  logic [NOC_DATA_WIDTH-1:0] head;
  logic                      in_tail, out_tail, in_tail_cnt, out_tail_cnt;

  // A packet is oversize when header + body cannot fit in the FIFO at once.
  function automatic logic is_ovs(input logic [7:0] len);
    return ({24'd0, len} + 32'd1) > 32'(FLIT_DEPTH);
  endfunction

  assign head     = mem[rd_ptr];
  assign in_len   = noc2_in_dat[29:22];
  assign head_len = head[29:22];
  assign push     = noc2_in_val && noc2_in_rdy;
  assign pop      = noc2_out_val && noc2_out_rdy;

  assign in_tail  = push && ((in_state == HDR  && in_len == 8'd0) ||
                             (in_state == BODY && in_rem == 8'd1));
  assign out_tail = pop  && ((out_state == HDR  && head_len == 8'd0) ||
                             (out_state == BODY && out_rem == 8'd1));
  // Oversize packets are never counted in pkt_cnt, on either side.
  assign in_tail_cnt  = in_tail  && !(in_state  == BODY && ovs);
  assign out_tail_cnt = out_tail && !(out_state == BODY && out_ovs);

  // ---------------- state registers ----------------
  always_ff @(posedge chipset_clk) begin
    if (chipset_rst) begin
      in_state  <= HDR;
      out_state <= HDR;
    end else begin
      in_state  <= in_state_nxt;
      out_state <= out_state_nxt;
    end
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    in_state_nxt = in_state;
    if (push) begin
      case (in_state)
        HDR:  if (in_len != 8'd0) in_state_nxt = BODY;
        BODY: if (in_rem == 8'd1) in_state_nxt = HDR;
        default: in_state_nxt = HDR;
      endcase
    end
  end

  always_comb begin
    out_state_nxt = out_state;
    if (pop) begin
      case (out_state)
        HDR:  if (head_len != 8'd0) out_state_nxt = BODY;
        BODY: if (out_rem == 8'd1)  out_state_nxt = HDR;
        default: out_state_nxt = HDR;
      endcase
    end
  end

  // ---------------- outputs ----------------
  // In HDR the egress waits for a complete packet, unless the head is the
  // header of an oversize packet, which must start draining before its tail
  // can ever be written. In BODY it streams whatever flits exist.
  always_comb begin
    noc2_in_rdy  = rst_done && !chipset_rst && (flit_cnt != CW'(FLIT_DEPTH));
    noc2_out_val = 1'b0;
    if (!chipset_rst) begin
      case (out_state)
        HDR:  noc2_out_val = (pkt_cnt_q != '0) || (ovs_head && flit_cnt != '0);
        BODY: noc2_out_val = (flit_cnt != '0);
        default: noc2_out_val = 1'b0;
      endcase
    end
  end

  assign noc2_out_dat = head;
  assign pkt_cnt      = pkt_cnt_q;

  // ---------------- FIFO storage ----------------
  always_ff @(posedge chipset_clk) begin
    if (push) mem[wr_ptr] <= noc2_in_dat;
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge chipset_clk) begin
    if (chipset_rst) begin
      rst_done  <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      flit_cnt  <= '0;
      pkt_cnt_q <= '0;
      in_rem    <= '0;
      out_rem   <= '0;
      ovs       <= 1'b0;
      ovs_head  <= 1'b0;
      out_ovs   <= 1'b0;
    end else begin
      rst_done <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;

      case ({push, pop})
        2'b10:   flit_cnt <= flit_cnt + 1'b1;
        2'b01:   flit_cnt <= flit_cnt - 1'b1;
        default: flit_cnt <= flit_cnt;
      endcase

      case ({in_tail_cnt, out_tail_cnt})
        2'b10:   pkt_cnt_q <= pkt_cnt_q + 1'b1;
        2'b01:   pkt_cnt_q <= pkt_cnt_q - 1'b1;
        default: pkt_cnt_q <= pkt_cnt_q;
      endcase

      if (push) begin
        if (in_state == HDR) begin
          in_rem <= in_len;
          ovs    <= (in_len != 8'd0) && is_ovs(in_len);
        end else begin
          in_rem <= in_rem - 8'd1;
          if (in_rem == 8'd1) ovs <= 1'b0;
        end
      end

      if (pop) begin
        if (out_state == HDR) begin
          out_rem <= head_len;
          out_ovs <= is_ovs(head_len);
        end else begin
          out_rem <= out_rem - 8'd1;
        end
      end

      // An oversize packet cannot complete until its header has left, so at
      // most one oversize header is ever waiting; the flag marks it until it
      // reaches the head and is popped. Complete packets ahead of it still
      // drain first through pkt_cnt.
      if (push && in_state == HDR && is_ovs(in_len))
        ovs_head <= 1'b1;
      else if (pop && out_state == HDR && is_ovs(head_len))
        ovs_head <= 1'b0;
    end
  end

  // ---------------- forwarded-packet statistics ----------------
`ifdef NCMEM_PKT_BUF_STATS_EN
  logic [31:0] fwd_q;
  always_ff @(posedge chipset_clk) begin
    if (chipset_rst)   fwd_q <= '0;
    else if (out_tail) fwd_q <= fwd_q + 32'd1;
  end
  assign pkt_fwd_cnt = fwd_q;
`else
  assign pkt_fwd_cnt = '0;
`endif

endmodule

// File: tb/tb_ncmem_noc2_pkt_buf.sv
// Directed bench for ncmem_noc2_pkt_buf (FLIT_DEPTH=16, 64-bit flits).
// Inputs are driven 1 time unit after each rising edge, outputs are sampled
// at the same point, away from the active edge.

module tb_ncmem_noc2_pkt_buf;

  localparam int D = 16;
`ifdef NCMEM_PKT_BUF_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_val;
  logic [63:0] in_dat;
  logic        in_rdy;
  logic        out_val;
  logic [63:0] out_dat;
  logic        out_rdy;
  logic [4:0]  pkt_cnt;
  logic [31:0] fwd_cnt;

  int total = 0;
  int bad   = 0;

  logic [63:0] vec [64];
  int          n_vec;
  int          cyc, hdr_c, tail_c;

  always #5 clk = ~clk;

  ncmem_noc2_pkt_buf #(.NOC_DATA_WIDTH(64), .FLIT_DEPTH(D)) dut (
    .chipset_clk  (clk),
    .chipset_rst  (rst),
    .noc2_in_val  (in_val),
    .noc2_in_dat  (in_dat),
    .noc2_in_rdy  (in_rdy),
    .noc2_out_val (out_val),
    .noc2_out_dat (out_dat),
    .noc2_out_rdy (out_rdy),
    .pkt_cnt      (pkt_cnt),
    .pkt_fwd_cnt  (fwd_cnt)
  );

  // Flit layout: len at [29:22], tag and index elsewhere for identification.
  function automatic logic [63:0] mk(input logic [7:0] tag, input logic [7:0] len,
                                     input logic [7:0] idx);
    return {8'hC0, tag, 16'h0, 2'b00, len, 14'h0, idx};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Push one flit, waiting (bounded) for ready.
  task automatic push(input logic [63:0] d);
    int n;
    in_val = 1'b1;
    in_dat = d;
    n = 0;
    while (!in_rdy && n < 50) begin
      step();
      n++;
    end
    chk("push_rdy", in_rdy, 1'b1);
    step();
    in_val = 1'b0;
  endtask

  // Cycle-accurate stream of vec[0..n_vec-1] in and out; out_rdy asserted
  // from cycle rdy_from onward. Every delivered flit is checked in order.
  task automatic run_stream(input int rdy_from, output int cycles,
                            output int hc, output int tc);
    int j, k, c;
    j = 0; k = 0; c = 0; hc = -1; tc = -1;
    while (k < n_vec && c < 300) begin
      out_rdy = (c >= rdy_from);
      in_val  = (j < n_vec);
      if (j < n_vec) in_dat = vec[j];
      if (rdy_from == 20 && c == 19) chk("ovs_full_rdy", in_rdy, 1'b0);
      if (out_val && out_rdy) begin
        chk("stream_dat", out_dat, vec[k]);
        if (k == 0) hc = c;
        k++;
      end
      if (in_val && in_rdy) begin
        if (j == n_vec - 1) tc = c;
        j++;
      end
      step();
      c++;
    end
    in_val  = 1'b0;
    out_rdy = 1'b0;
    cycles  = c;
    chk("stream_done", 64'(k), 64'(n_vec));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---- T1 reset with in_val held high ----
    rst = 1'b1; in_val = 1'b1; in_dat = mk(8'h01, 8'd0, 8'd0); out_rdy = 1'b0;
    repeat (3) step();
    chk("rst_in_rdy",  in_rdy,  1'b0);
    chk("rst_out_val", out_val, 1'b0);
    chk("rst_pkt_cnt", pkt_cnt, 5'd0);
    chk("rst_fwd_cnt", fwd_cnt, 32'd0);
    rst = 1'b0; in_val = 1'b0;
    chk("rel_rdy_low", in_rdy, 1'b0);
    step();
    chk("rel_rdy_high", in_rdy,  1'b1);
    chk("rel_no_push",  out_val, 1'b0);

    // ---- T2 hold until complete ----
    push(mk(8'h02, 8'd2, 8'd0));
    push(mk(8'h02, 8'd0, 8'd1));
    for (int i = 0; i < 5; i++) begin
      chk("hold_val", out_val, 1'b0);
      step();
    end
    push(mk(8'h02, 8'd0, 8'd2));
    chk("hold_tail_val", out_val, 1'b1);
    chk("hold_pkt_cnt",  pkt_cnt, 5'd1);
    out_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("hold_out_val", out_val, 1'b1);
      chk("hold_out_dat", out_dat, (i == 0) ? mk(8'h02, 8'd2, 8'd0) : mk(8'h02, 8'd0, 8'(i)));
      step();
    end
    out_rdy = 1'b0;
    chk("hold_empty_val", out_val, 1'b0);
    chk("hold_empty_cnt", pkt_cnt, 5'd0);

    // ---- T3 full ----
    for (int i = 0; i < 16; i++) push(mk(8'h03, 8'd0, 8'(i)));
    chk("full_rdy",     in_rdy,  1'b0);
    chk("full_pkt_cnt", pkt_cnt, 5'd16);
    chk("full_head",    out_dat, mk(8'h03, 8'd0, 8'd0));
    out_rdy = 1'b1;
    step();
    out_rdy = 1'b0;
    chk("full_pop_rdy", in_rdy,  1'b1);
    chk("full_pop_cnt", pkt_cnt, 5'd15);
    out_rdy = 1'b1;
    for (int i = 1; i < 16; i++) begin
      chk("full_drain_val", out_val, 1'b1);
      chk("full_drain_dat", out_dat, mk(8'h03, 8'd0, 8'(i)));
      step();
    end
    out_rdy = 1'b0;
    chk("full_drained", out_val, 1'b0);

    // ---- T4 simultaneous tail push and tail pop ----
    push(mk(8'h04, 8'd0, 8'd1));
    out_rdy = 1'b1; in_val = 1'b1; in_dat = mk(8'h04, 8'd0, 8'd2);
    chk("sim_pre_val", out_val, 1'b1);
    step();
    in_val = 1'b0;
    chk("sim_pkt_cnt", pkt_cnt, 5'd1);
    chk("sim_out_val", out_val, 1'b1);
    chk("sim_out_dat", out_dat, mk(8'h04, 8'd0, 8'd2));
    step();
    out_rdy = 1'b0;
    chk("sim_empty_val", out_val, 1'b0);
    chk("sim_empty_cnt", pkt_cnt, 5'd0);

    // ---- T5 oversize: 21 flits through a 16-deep FIFO ----
    vec[0] = mk(8'h05, 8'd20, 8'd0);
    for (int i = 1; i < 21; i++) vec[i] = mk(8'h05, 8'd0, 8'(i));
    n_vec = 21;
    run_stream(20, cyc, hdr_c, tail_c);
    chk("ovs_cut_through", (hdr_c >= 0 && hdr_c < tail_c), 1'b1);
    chk("ovs_end_val", out_val, 1'b0);
    chk("ovs_end_cnt", pkt_cnt, 5'd0);
    chk("ovs_end_rdy", in_rdy,  1'b1);

    // ---- T6 stats: 1 + 16 + 2 + 1 packets forwarded so far ----
    chk("fwd_20", fwd_cnt, (STATS != 0) ? 32'd20 : 32'd0);

    // Reset in the middle of a packet discards it and clears the counter.
    push(mk(8'h06, 8'd3, 8'd0));
    push(mk(8'h06, 8'd0, 8'd1));
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_cnt", pkt_cnt, 5'd0);
    chk("mid_rst_val", out_val, 1'b0);
    chk("mid_rst_fwd", fwd_cnt, 32'd0);
    chk("mid_rst_rdy", in_rdy,  1'b0);
    step();
    chk("mid_rel_rdy", in_rdy, 1'b1);

    // Five back-to-back single-flit packets: one flit per cycle, 1-cycle latency.
    for (int i = 0; i < 5; i++) vec[i] = mk(8'h07, 8'd0, 8'(i));
    n_vec = 5;
    run_stream(0, cyc, hdr_c, tail_c);
    chk("b2b_cycles", 64'(cyc), 64'd6);
    chk("fwd_5", fwd_cnt, (STATS != 0) ? 32'd5 : 32'd0);
    chk("b2b_end_cnt", pkt_cnt, 5'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
